// File: rtl/alu_sched.sv
// alu_sched
// Round-robin scheduler that shares one registered 4-bit ALU among N_REQ
// requesters. A request is accepted in IDLE and its operands are registered
// onto the ALU ports. The result comes back two cycles later, while the FSM is
// in WAIT, and is latched there. It is then presented to the granted requester
// on a held response handshake.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid / req_ready   per-requester request handshake; ready is one-hot or zero
//   req_a, req_b, req_c     packed 4-bit operands, requester i at [4i+3:4i]
//   req_m                   packed 2-bit op codes, requester i at [2i+1:2i]
//   rsp_valid / rsp_ready   per-requester response handshake; valid is one-hot
//   rsp_out, rsp_err, rsp_cay  latched ALU result, error and carry flags
//   alu_a, alu_b, alu_c, alu_m registered operands / op code driven to the ALU
//   alu_out, alu_err, alu_cay  ALU result, registered inside the ALU
//   busy                    high whenever the FSM is not in IDLE
module alu_sched #(
  parameter int N_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_a,
  input  logic [4*N_REQ-1:0] req_b,
  input  logic [4*N_REQ-1:0] req_c,
  input  logic [2*N_REQ-1:0] req_m,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [4:0]         rsp_out,
  output logic               rsp_err,
  output logic               rsp_cay,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [3:0]         alu_c,
  output logic [1:0]         alu_m,
  input  logic [4:0]         alu_out,
  input  logic               alu_err,
  input  logic               alu_cay,
  output logic               busy
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   lastGrant_q, lastGrant_d;
  logic [3:0]      aluA_q, aluB_q, aluC_q;
  logic [1:0]      aluM_q;
  logic [4:0]      rspOut_q;
  logic            rspErr_q, rspCay_q;

  logic            anyValid;
  logic            accept;
  logic [GW-1:0]   pick;

  // Round-robin search: the candidate closest after 'last' wins. The scan runs
  // from the farthest offset down to the nearest, so the nearest valid
  // requester overwrites any farther one.
  function automatic logic [GW-1:0] rrPick(input logic [N_REQ-1:0] valid,
                                           input logic [GW-1:0]    last);
    logic [GW-1:0] sel;
    logic [GW-1:0] cand;
    int            idx;
    sel = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx  = (int'(last) + k) % N_REQ;
      cand = GW'(idx);
      if (valid[cand]) begin
        sel = cand;
      end
    end
    return sel;
  endfunction

  // Arbitration is purely combinational so that req_ready can complete the
  // handshake in the same IDLE cycle in which the request is seen. It is
  // gated by rst_n so that nothing is accepted while reset is held.
  always_comb begin
    anyValid  = |req_valid;
    pick      = rrPick(req_valid, lastGrant_q);
    accept    = (state_q == IDLE) && anyValid;
    req_ready = (accept && rst_n) ? (N_REQ'(1) << pick) : '0;
    rsp_valid = (state_q == RESP) ? (N_REQ'(1) << grant_q) : '0;
    busy      = (state_q != IDLE);
  end

  // Next-state logic. The last-grant pointer only advances once the response
  // has been taken. Dropped ops (reset) therefore do not disturb the rotation
  // beyond the reset value.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    unique case (state_q)
      IDLE: begin
        if (anyValid) begin
          grant_d = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          lastGrant_d = grant_q;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers. lastGrant resets to N_REQ-1 so that requester 0 is the
  // first one considered after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      lastGrant_q <= GW'(N_REQ - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Datapath registers. The ALU operands are loaded on accept and then held
  // until the next accept. The result is captured in WAIT, when the
  // registered ALU outputs reflect the issued op. The ALU leaves its carry
  // stale on shift and error ops, so the carry is only kept for op 01.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluA_q   <= '0;
      aluB_q   <= '0;
      aluC_q   <= '0;
      aluM_q   <= '0;
      rspOut_q <= '0;
      rspErr_q <= 1'b0;
      rspCay_q <= 1'b0;
    end else begin
      if (accept) begin
        aluA_q <= req_a[{pick, 2'b00} +: 4];
        aluB_q <= req_b[{pick, 2'b00} +: 4];
        aluC_q <= req_c[{pick, 2'b00} +: 4];
        aluM_q <= req_m[{pick, 1'b0} +: 2];
      end
      if (state_q == WAIT) begin
        rspOut_q <= alu_out;
        rspErr_q <= alu_err;
        rspCay_q <= (aluM_q == 2'b01) ? alu_cay : 1'b0;
      end
    end
  end

  assign alu_a   = aluA_q;
  assign alu_b   = aluB_q;
  assign alu_c   = aluC_q;
  assign alu_m   = aluM_q;
  assign rsp_out = rspOut_q;
  assign rsp_err = rspErr_q;
  assign rsp_cay = rspCay_q;

endmodule
